// File: rtl/wav_playback_sequencer.sv
// Playback sequencer: fetches packed stereo frames from a sample buffer and streams them as L/R AXIS beats.
// Optional feature macro VOLUME_EN adds a per-frame arithmetic volume shift (vol_shift port).
module wav_playback_sequencer #(
    parameter int ADDR_W = 16,
    parameter int OUT_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_count,
`ifdef VOLUME_EN
    input  logic [3:0]        vol_shift,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] frames_played
);

    localparam int                PAD_W  = OUT_W - 16;
    localparam logic [ADDR_W-1:0] ZERO_C = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SEND_L = 3'd3,
        ST_SEND_R = 3'd4,
        ST_PAUSED = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] frames_played_r;
    logic [31:0]       frame_r;
    logic [31:0]       captured_s;
    logic              stop_flag_r;
    logic              start_ok_s;
    logic              last_s;
    logic              stop_now_s;
    logic              hs_r_s;
    logic              mem_rd_en_r;
    logic              tvalid_r;
    logic              tlast_r;
    logic              busy_r;
    logic              done_r;
    logic [OUT_W-1:0]  tdata_r;
    logic [OUT_W-1:0]  tdata_nxt_s;

`ifdef VOLUME_EN
    function automatic logic [15:0] scale_sample(input logic [15:0] s, input logic [3:0] sh);
        scale_sample = 16'($signed(s) >>> sh);
    endfunction

    assign captured_s = {scale_sample(mem_rd_data[31:16], vol_shift),
                         scale_sample(mem_rd_data[15:0], vol_shift)};
`else
    assign captured_s = mem_rd_data;
`endif

    assign start_ok_s = (state_r == ST_IDLE) && start;
    assign last_s     = (remaining_r == ONE_C);
    assign stop_now_s = stop_flag_r | stop;
    assign hs_r_s     = (state_r == ST_SEND_R) && m_axis_tready;

    // Next-state decision; stop is only honoured at frame boundaries except while paused.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (frame_count != ZERO_C) ? ST_FETCH : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH:  state_nxt_s = ST_WAIT;
            ST_WAIT:   state_nxt_s = ST_SEND_L;
            ST_SEND_L: begin
                if (m_axis_tready) begin
                    state_nxt_s = ST_SEND_R;
                end else begin
                    state_nxt_s = ST_SEND_L;
                end
            end
            ST_SEND_R: begin
                if (!m_axis_tready) begin
                    state_nxt_s = ST_SEND_R;
                end else if (stop_now_s || (last_s && !loop_en)) begin
                    state_nxt_s = ST_DONE;
                end else if (pause) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_nxt_s = ST_DONE;
                end else if (!pause) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Beat payload for the coming cycle; the left sample bypasses frame_r on the WAIT->SEND_L edge.
    always_comb begin
        tdata_nxt_s = {OUT_W{1'b0}};
        case (state_nxt_s)
            ST_SEND_L: begin
                if (state_r == ST_WAIT) begin
                    tdata_nxt_s = {captured_s[31:16], {PAD_W{1'b0}}};
                end else begin
                    tdata_nxt_s = {frame_r[31:16], {PAD_W{1'b0}}};
                end
            end
            ST_SEND_R: tdata_nxt_s = {frame_r[15:0], {PAD_W{1'b0}}};
            default:   tdata_nxt_s = {OUT_W{1'b0}};
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_rd_en_r <= 1'b0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tdata_r     <= {OUT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_rd_en_r <= (state_nxt_s == ST_FETCH);
            tvalid_r    <= (state_nxt_s == ST_SEND_L) || (state_nxt_s == ST_SEND_R);
            tlast_r     <= (state_nxt_s == ST_SEND_R);
            tdata_r     <= tdata_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Playback datapath: latched parameters, address walk, frame buffer and sticky stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_r          <= ZERO_C;
            count_r         <= ZERO_C;
            remaining_r     <= ZERO_C;
            addr_r          <= ZERO_C;
            frames_played_r <= ZERO_C;
            frame_r         <= 32'h0000_0000;
            stop_flag_r     <= 1'b0;
        end else begin
            if (start_ok_s) begin
                frames_played_r <= ZERO_C;
                if (frame_count != ZERO_C) begin
                    base_r      <= base_addr;
                    count_r     <= frame_count;
                    remaining_r <= frame_count;
                    addr_r      <= base_addr;
                end
            end else if (hs_r_s) begin
                frames_played_r <= frames_played_r + ONE_C;
                if (last_s) begin
                    addr_r      <= base_r;
                    remaining_r <= count_r;
                end else begin
                    addr_r      <= addr_r + ONE_C;
                    remaining_r <= remaining_r - ONE_C;
                end
            end

            if (state_r == ST_WAIT) begin
                frame_r <= captured_s;
            end

            if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
                stop_flag_r <= 1'b0;
            end else if (stop && (state_r != ST_PAUSED)) begin
                stop_flag_r <= 1'b1;
            end
        end
    end

    assign mem_rd_en     = mem_rd_en_r;
    assign mem_addr      = addr_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign frames_played = frames_played_r;

endmodule

// File: tb/tb_wav_playback_sequencer.sv
// Self-checking bench for wav_playback_sequencer: directed and randomized playback runs against a frame-list model.
// Honours VOLUME_EN when the design is built with it.
module tb_wav_playback_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop, pause, loop_en;
    logic [15:0] base_addr, frame_count;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data = 32'h0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        busy, done;
    logic [15:0] frames_played;
`ifdef VOLUME_EN
    logic [3:0]  vol_shift;
`endif

    logic [31:0] mem [0:65535];
    logic [31:0] beat_q[$];
    logic [15:0] rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt, done_cyc, first_tv, first_rd, t0;
    bit          rand_ready = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] held;

    wav_playback_sequencer #(.ADDR_W(16), .OUT_W(24)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .base_addr(base_addr), .frame_count(frame_count),
`ifdef VOLUME_EN
        .vol_shift(vol_shift),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .frames_played(frames_played)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clock);
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observer: collects handshaken beats, fetch addresses, done pulses; checks AXIS hold rule.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                chk("axis_hold", {6'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, held);
            hold_pending = m_axis_tvalid && !m_axis_tready;
            held = {6'd0, 1'b1, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) beat_q.push_back({7'd0, m_axis_tlast, m_axis_tdata});
            if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
            if (mem_rd_en) begin
                rd_q.push_back(mem_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_obs();
        beat_q.delete();
        rd_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_tv = -1;
        first_rd = -1;
    endtask

    function automatic logic [23:0] exp_sample(input logic [15:0] s);
`ifdef VOLUME_EN
        int v;
        v = int'($signed(s));
        v = v >>> vol_shift;
        exp_sample = {v[15:0], 8'h00};
`else
        exp_sample = {s, 8'h00};
`endif
    endfunction

    // Plays one run and compares against the frame list implied by base/count/loop/stop.
    task automatic play(input logic [15:0] b, input logic [15:0] cnt, input bit lp,
                        input int stop_frame, input bit use_pause, input bit junk);
        int n, it;
        bit stopped, released;
        logic [15:0] a;
        clear_obs();
        base_addr = b; frame_count = cnt; loop_en = lp; pause = use_pause;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        it = 0; stopped = 1'b0; released = 1'b0;
        while (done_cnt == 0 && it < 400) begin
            if (junk && it == 3) begin
                start = 1'b1; base_addr = ~b; frame_count = 16'd7;
            end
            if (stop_frame != 0 && !stopped && m_axis_tvalid && !m_axis_tlast &&
                beat_q.size() == 2 * (stop_frame - 1)) begin
                stop = 1'b1; stopped = 1'b1;
                if (junk) begin
                    start = 1'b1; base_addr = ~b; frame_count = 16'd9;
                end
            end
            if (use_pause && !released && beat_q.size() >= 2) begin
                repeat (6) tick();
                chk("paused_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
                chk("paused_busy", {31'd0, busy}, 32'd1);
                chk("paused_no_fetch", rd_q.size(), 32'd1);
                pause = 1'b0; released = 1'b1;
            end
            tick();
            it++;
            start = 1'b0; stop = 1'b0; base_addr = b; frame_count = cnt;
        end
        chk("done_timeout", {31'd0, (done_cnt > 0)}, 32'd1);
        tick(); tick();

        if (cnt == 16'd0) n = 0;
        else if (stop_frame != 0 && (lp || stop_frame <= int'(cnt))) n = stop_frame;
        else n = int'(cnt);

        chk("beat_count", beat_q.size(), 2 * n);
        chk("fetch_count", rd_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i % int'(cnt));
            if (i < rd_q.size()) chk("fetch_addr", {16'd0, rd_q[i]}, {16'd0, a});
            if (2 * i + 1 < beat_q.size()) begin
                chk("beat_left", beat_q[2*i], {8'd0, exp_sample(mem[a][31:16])});
                chk("beat_right", beat_q[2*i+1], {7'd0, 1'b1, exp_sample(mem[a][15:0])});
            end
        end
        chk("frames_played", {16'd0, frames_played}, 32'(n) & 32'h0000_FFFF);
        chk("done_once", done_cnt, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        base_addr = 16'h0; frame_count = 16'h0; m_axis_tready = 1'b1;
`ifdef VOLUME_EN
        vol_shift = 4'd0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0010] = 32'h1234_ABCD;
        mem[16'h0011] = 32'h8000_7FFF;
        clear_obs();
        repeat (3) tick();
        chk("rst_outputs", {mem_rd_en, m_axis_tvalid, m_axis_tlast, busy, done}, 32'd0);
        chk("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
        chk("rst_addr_fp", {mem_addr, frames_played}, 32'd0);
        reset = 1'b0;
        tick();

        // Reference two-frame run with fixed latency.
        play(16'h0010, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        chk("rd_latency", first_rd, t0);
        chk("tvalid_latency", first_tv, t0 + 2);
        chk("done_latency", done_cyc, t0 + 8);
        if (beat_q.size() > 0) chk("beat0_const", beat_q[0], 32'h0012_3400);

        // Back-pressure during the left beat.
        clear_obs();
        m_axis_tready = 1'b0;
        base_addr = 16'h0010; frame_count = 16'd1; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("stall_tdata", {8'd0, m_axis_tdata}, 32'h0012_3400);
            tick();
        end
        chk("stall_no_refetch", rd_q.size(), 32'd1);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 20 && done_cnt == 0; i++) tick();
        tick();
        chk("stall_beats", beat_q.size(), 32'd2);
        if (beat_q.size() == 2) chk("stall_right", beat_q[1], 32'h01AB_CD00);
        chk("stall_done", done_cnt, 32'd1);

        // Looping with stop (plus an ignored start) during frame 5.
        play(16'h0010, 16'd3, 1'b1, 5, 1'b0, 1'b1);
        // Address wrap.
        play(16'hFFFF, 16'd2, 1'b0, 0, 1'b0, 1'b0);
        // Pause between frames.
        play(16'h0020, 16'd3, 1'b0, 0, 1'b1, 1'b0);

        // Zero-length start.
        clear_obs();
        base_addr = 16'h0030; frame_count = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        t0 = cyc;
        repeat (4) tick();
        chk("cnt0_done_cycle", done_cyc, t0);
        chk("cnt0_done_once", done_cnt, 32'd1);
        chk("cnt0_no_tvalid", first_tv, -1);
        chk("cnt0_no_fetch", rd_q.size(), 32'd0);

        // Randomized runs with random back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            logic [15:0] rb, rc;
            bit rl;
            int sf;
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
            rc = 16'($urandom_range(1, 4));
            rl = $urandom_range(0, 1) == 1;
            if (rl) sf = int'(rc) + $urandom_range(0, 3);
            else if ($urandom_range(0, 1) == 1) sf = $urandom_range(1, int'(rc));
            else sf = 0;
`ifdef VOLUME_EN
            vol_shift = 4'($urandom_range(0, 15));
`endif
            play(rb, rc, rl, sf, 1'b0, (r % 2) == 1);
        end
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;

        // Reset in the middle of a stream.
        clear_obs();
        base_addr = 16'h0040; frame_count = 16'd4; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (12) tick();
        chk("midrst_no_done", done_cnt, 32'd0);

`ifdef VOLUME_EN
        vol_shift = 4'd4;
        play(16'h0011, 16'd1, 1'b0, 0, 1'b0, 1'b0);
        if (beat_q.size() > 0) chk("vol_left", beat_q[0], 32'h00F8_0000);
        vol_shift = 4'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
